// File: rtl/dma_dev_endpoint_pkg.sv
// Shared definitions for the DMA device endpoint: default widths, FSM states and error codes.
// The width defaults match dma_controller so both sides of the link agree.
package dma_dev_endpoint_pkg;

  localparam int DEF_ADD_LEN    = 16;
  localparam int DEF_DATA_LEN   = 16;
  localparam int DEF_FIFO_DEPTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN   = 2'd1;
  localparam logic [1:0] ERR_EARLY_END = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  // Legal word counts are 1..2^depth; the full buffer encodes as 0 on num_words.
  function automatic logic len_ok(input logic [31:0] len, input int depth);
    return (len != 32'd0) && (len <= (32'd1 << depth));
  endfunction

endpackage

// File: rtl/dma_dev_endpoint_buf.sv
// Endpoint word buffer: one synchronous write port, two combinational read ports.
// Contents are deliberately not reset so data survives an aborted transfer.
module dma_dev_endpoint_buf #(
  parameter int DATA_LEN   = 16,
  parameter int FIFO_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [FIFO_DEPTH-1:0] i_waddr,
  input  logic [DATA_LEN-1:0]   i_wdata,
  input  logic [FIFO_DEPTH-1:0] i_host_addr,
  output logic [DATA_LEN-1:0]   o_host_rdata,
  input  logic [FIFO_DEPTH-1:0] i_xfer_addr,
  output logic [DATA_LEN-1:0]   o_xfer_rdata
);

  logic [DATA_LEN-1:0] r_mem [1<<FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_host_rdata = r_mem[i_host_addr];
  assign o_xfer_rdata = r_mem[i_xfer_addr];

endmodule

// File: rtl/dma_dev_endpoint.sv
// Device-side endpoint of the DMA link: takes host commands, requests the controller,
// then sources (write) or sinks (read) buffer words until end_flag closes the transfer.
module dma_dev_endpoint
  import dma_dev_endpoint_pkg::*;
#(
  parameter int ADD_LEN     = DEF_ADD_LEN,
  parameter int DATA_LEN    = DEF_DATA_LEN,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_start,
  input  logic                  i_cmd_dir,
  input  logic [ADD_LEN-1:0]    i_cmd_addr,
  input  logic [FIFO_DEPTH:0]   i_cmd_len,
  input  logic                  i_dev_ready,
  input  logic                  i_buf_we,
  input  logic [FIFO_DEPTH-1:0] i_buf_addr,
  input  logic [DATA_LEN-1:0]   i_buf_wdata,
  output logic [DATA_LEN-1:0]   o_buf_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic                  o_rqst,
  output logic [ADD_LEN-1:0]    o_start_addr,
  output logic [FIFO_DEPTH-1:0] o_num_words,
  output logic                  o_rd_wr,
  output logic                  o_dev_ack,
  output logic [DATA_LEN-1:0]   o_dev_in,
  input  logic                  i_dma_ack,
  input  logic [DATA_LEN-1:0]   i_dev_out,
  input  logic                  i_end_flag,
  output state_t                o_state
);

  // Word handshake: o_dev_ack means "endpoint ready" (read) or "o_dev_in valid" (write);
  // a word moves on every rising edge where o_dev_ack and i_dma_ack are both high.

  state_t                r_state, w_state_nxt;
  logic [ADD_LEN-1:0]    r_addr;
  logic                  r_dir;
  logic [FIFO_DEPTH:0]   r_len;
  logic [FIFO_DEPTH-1:0] r_idx;
  logic [FIFO_DEPTH:0]   r_cnt;
  logic [31:0]           r_tmo;
  logic                  r_dev_ack;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic                  w_in_xfer, w_take, w_activity, w_tmo_hit, w_len_ok, w_accept;
  logic [FIFO_DEPTH:0]   w_cnt_after;
  logic                  w_err_set;
  logic [1:0]            w_err_code_nxt;
  logic                  w_buf_we;
  logic [FIFO_DEPTH-1:0] w_buf_waddr;
  logic [DATA_LEN-1:0]   w_buf_wdata, w_xfer_rdata;

  assign w_in_xfer   = (r_state == ST_XFER);
  // cnt saturates at len, so surplus dma_ack pulses neither count nor wrap idx.
  assign w_take      = w_in_xfer && r_dev_ack && i_dma_ack && (r_cnt != r_len);
  assign w_cnt_after = r_cnt + (FIFO_DEPTH+1)'(w_take);
  assign w_activity  = i_dma_ack || i_end_flag;
  assign w_tmo_hit   = (TIMEOUT_CYC != 0) && !w_activity && (r_tmo == 32'(TIMEOUT_CYC - 1));
  assign w_len_ok    = len_ok(32'(i_cmd_len), FIFO_DEPTH);
  assign w_accept    = (r_state == ST_IDLE) && i_cmd_start && w_len_ok;

  always_comb begin
    w_state_nxt    = r_state;
    w_err_set      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_start) begin
          if (w_len_ok) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt    = ST_ERR;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_BAD_LEN;
          end
        end
      end
      ST_REQ:  w_state_nxt = ST_XFER;
      ST_XFER: begin
        if (i_end_flag) begin
          if (w_cnt_after == r_len) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt    = ST_ERR;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_EARLY_END;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt    = ST_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_dir      <= 1'b0;
      r_len      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_dev_ack  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_dev_ack <= i_dev_ready;
      if (w_accept) begin
        r_addr     <= i_cmd_addr;
        r_dir      <= i_cmd_dir;
        r_len      <= i_cmd_len;
        r_idx      <= '0;
        r_cnt      <= '0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end else if (w_take) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= w_cnt_after;
      end
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_nxt;
      end
      if (!w_in_xfer || w_activity) r_tmo <= '0;
      else                          r_tmo <= r_tmo + 32'd1;
    end
  end

  // Transfer writes take the port during a read; host writes are only honoured when idle.
  assign w_buf_we    = (w_take && r_dir) || (!o_busy && i_buf_we);
  assign w_buf_waddr = (w_take && r_dir) ? r_idx : i_buf_addr;
  assign w_buf_wdata = (w_take && r_dir) ? i_dev_out : i_buf_wdata;

  dma_dev_endpoint_buf #(
    .DATA_LEN  (DATA_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk         (clk),
    .i_we        (w_buf_we),
    .i_waddr     (w_buf_waddr),
    .i_wdata     (w_buf_wdata),
    .i_host_addr (i_buf_addr),
    .o_host_rdata(o_buf_rdata),
    .i_xfer_addr (r_idx),
    .o_xfer_rdata(w_xfer_rdata)
  );

  assign o_busy       = (r_state == ST_REQ) || w_in_xfer;
  assign o_rqst       = (r_state == ST_REQ);
  assign o_done       = (r_state == ST_DONE);
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_start_addr = o_busy ? r_addr : '0;
  assign o_num_words  = o_busy ? r_len[FIFO_DEPTH-1:0] : '0;
  assign o_rd_wr      = o_busy && r_dir;
  assign o_dev_ack    = w_in_xfer && r_dev_ack;
  assign o_dev_in     = (w_in_xfer && !r_dir) ? w_xfer_rdata : '0;
  assign o_state      = r_state;

endmodule
